// File: rtl/move_request_arbiter.sv
// move_request_arbiter
//   Front end for the 2048 core's direction input. It synchronizes and
//   debounces four raw buttons, keeps only the highest-priority press when
//   several land in the same cycle, buffers accepted moves in a small FIFO,
//   and presents them one at a time as a one-hot direction over valid/ready.
//
//   Event pipeline, with a steady raw press first sampled at edge 0:
//     edge 1      second synchronizer flop sees the press
//     edge D+1    debounced level goes PRESSED (D = DEBOUNCE_CYCLES)
//     edge D+2    edge-detected press is arbitrated and registered (acc_q)
//     edge D+3    push into the FIFO; dir_valid rises if the FIFO was empty
//
//   Optional feature macro: MOVE_AUTO_REPEAT_EN. When it is defined, a held
//   button re-fires every REPEAT_CYCLES cycles. When it is undefined, no
//   repeat logic is built and REPEAT_CYCLES has no effect.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active high
//   btn_raw     raw async buttons: [0] top, [1] bottom, [2] left, [3] right
//   game_state  00 not_playing, 01 playing, 10 win, 11 lose
//   core_ready  core can accept a move this cycle
//   dir_valid   a move is presented on direction
//   direction   one-hot move; 0 when !dir_valid
//   pending     moves buffered, including the presented one
//   overflow    sticky: a press was dropped because the FIFO was full

// Per-button synchronizer plus RELEASED/PRESSED debounce FSM.
module move_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);
  typedef enum logic {RELEASED = 1'b0, PRESSED = 1'b1} deb_state_e;

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]    sync_q;
  deb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          differ;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= RELEASED;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter holds how many consecutive cycles the input has disagreed
  // with the level. The level toggles on the cycle after that count reaches
  // D-1, which means the input must disagree for D cycles in a row.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    differ  = sync_q[1] != (state_q == PRESSED);
    if (differ) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        state_d = (state_q == PRESSED) ? RELEASED : PRESSED;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign level = (state_q == PRESSED);
endmodule

module move_request_arbiter #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_CYCLES   = 5000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [3:0]                      btn_raw,
  input  logic [1:0]                      game_state,
  input  logic                            core_ready,
  output logic                            dir_valid,
  output logic [3:0]                      direction,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] pending,
  output logic                            overflow
);
  localparam int NUM_LANES = 4;
  localparam int PW        = $clog2(FIFO_DEPTH + 1);
  localparam int AW        = $clog2(FIFO_DEPTH);

  logic [NUM_LANES-1:0] lvl, lvl_q, press_ev, rep_ev, ev, pick, acc_q;
  logic                 playing, push, pop, full, push_ok;

  logic [FIFO_DEPTH-1:0][NUM_LANES-1:0] mem;
  logic [AW-1:0]                        wr_ptr, rd_ptr;
  logic [PW-1:0]                        count;

  assign playing = (game_state == 2'b01);

  move_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb [NUM_LANES-1:0] (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_raw),
    .level (lvl)
  );

  // Rising edge of the debounced level is the press event. Because the
  // debounce FSMs run regardless of game_state, a button held through a
  // flush does not fire again until it is released and pressed.
  always_ff @(posedge clk) begin
    if (rst) lvl_q <= '0;
    else     lvl_q <= lvl;
  end
  assign press_ev = lvl & ~lvl_q;

  // Keep only the lowest set bit: top > bottom > left > right.
  assign ev   = press_ev | rep_ev;
  assign pick = ev & (~ev + NUM_LANES'(1));

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= playing ? pick : '0;
  end

  assign push    = (|acc_q) && playing;
  assign full    = (count == PW'(FIFO_DEPTH));
  assign dir_valid = (count != '0) && playing;
  assign pop     = dir_valid && core_ready;
  // When the FIFO is full, a pop in the same cycle frees the head slot.
  // That slot is the one wr_ptr points at, so the push can use it.
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (!playing) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + PW'(1);
        2'b01:   count <= count - PW'(1);
        default: count <= count;
      endcase
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= acc_q;
  end

  assign direction = dir_valid ? mem[rd_ptr] : '0;
  assign pending   = count;

`ifdef MOVE_AUTO_REPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  logic                 acc_rep_q, rep_arm_q;
  logic [NUM_LANES-1:0] rep_lane_q, rep_ev_q;
  logic [RW-1:0]        rep_cnt_q;

  // Mark entries that came only from the repeat timer. Those entries must
  // not re-arm the timer, or the repeat period would stretch by the
  // length of the pipeline.
  always_ff @(posedge clk) begin
    if (rst) acc_rep_q <= 1'b0;
    else     acc_rep_q <= ~|(pick & press_ev);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_arm_q  <= 1'b0;
      rep_lane_q <= '0;
      rep_cnt_q  <= '0;
      rep_ev_q   <= '0;
    end else begin
      rep_ev_q <= '0;
      if (!playing) begin
        rep_arm_q <= 1'b0;
      end else if (push && !acc_rep_q) begin
        // A new real press re-arms the timer. A dropped push leaves it idle.
        rep_arm_q  <= push_ok;
        rep_lane_q <= acc_q;
        rep_cnt_q  <= '0;
      end else if (rep_arm_q && !(|(lvl & rep_lane_q))) begin
        rep_arm_q <= 1'b0;
      end else if (rep_arm_q) begin
        if (rep_cnt_q == RW'(REPEAT_CYCLES - 1)) begin
          rep_cnt_q <= '0;
          rep_ev_q  <= rep_lane_q;
        end else begin
          rep_cnt_q <= rep_cnt_q + RW'(1);
        end
      end
    end
  end

  assign rep_ev = rep_ev_q;
`else
  assign rep_ev = '0;
`endif
endmodule

// File: tb/tb_move_request_arbiter.sv
module tb_move_request_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_raw;
  logic [1:0] game_state;
  logic       core_ready;
  logic       dir_valid;
  logic [3:0] direction;
  logic [2:0] pending;
  logic       overflow;

  int tests = 0;
  int fails = 0;
  int moves;
  int exp_moves;

  move_request_arbiter #(
    .DEBOUNCE_CYCLES(4),
    .FIFO_DEPTH     (4),
    .REPEAT_CYCLES  (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .game_state (game_state),
    .core_ready (core_ready),
    .dir_valid  (dir_valid),
    .direction  (direction),
    .pending    (pending),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] b);
    btn_raw = b;
    repeat (8) tick();
    btn_raw = 4'b0000;
    repeat (8) tick();
  endtask

  initial begin
    rst = 1'b1; btn_raw = 4'b0000; game_state = 2'b01; core_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(dir_valid), 32'd0);
    chk("rst_dir",   32'(direction), 32'd0);
    chk("rst_pend",  32'(pending),   32'd0);
    chk("rst_ovf",   32'(overflow),  32'd0);
    rst = 1'b0;
    tick(); tick();

    // Hold top: the move appears after relative edge 7 and stays put.
    btn_raw = 4'b0001;
    repeat (7) tick();
    chk("lat_early", 32'(dir_valid), 32'd0);
    tick();
    chk("lat_valid", 32'(dir_valid), 32'd1);
    chk("lat_dir",   32'(direction), 32'h1);
    chk("lat_pend",  32'(pending),   32'd1);
    repeat (5) tick();
    chk("hold_dir",  32'(direction), 32'h1);
    btn_raw = 4'b0000;
    repeat (10) tick();
    chk("hold_pend", 32'(pending), 32'd1);
    core_ready = 1'b1; tick(); core_ready = 1'b0;
    chk("pop_pend",  32'(pending),   32'd0);
    chk("pop_valid", 32'(dir_valid), 32'd0);

    // Glitch: three cycles high is too short to toggle.
    btn_raw = 4'b0100;
    repeat (3) tick();
    btn_raw = 4'b0000;
    repeat (12) tick();
    chk("glitch_pend",  32'(pending),   32'd0);
    chk("glitch_valid", 32'(dir_valid), 32'd0);

    // Simultaneous bottom + right: bottom wins and is the only entry.
    btn_raw = 4'b1010;
    repeat (10) tick();
    chk("simul_pend", 32'(pending),   32'd1);
    chk("simul_dir",  32'(direction), 32'h2);
    btn_raw = 4'b0000;
    repeat (10) tick();
    chk("simul_pend2", 32'(pending), 32'd1);
    core_ready = 1'b1; tick(); core_ready = 1'b0;
    chk("simul_drain", 32'(pending), 32'd0);

    // Overflow: the fifth press is dropped and the drain keeps press order.
    press(4'b0001); press(4'b0010); press(4'b0100); press(4'b1000);
    chk("fill_ovf", 32'(overflow), 32'd0);
    press(4'b0001);
    chk("ovf_pend", 32'(pending),   32'd4);
    chk("ovf_flag", 32'(overflow),  32'd1);
    chk("ovf_head", 32'(direction), 32'h1);
    core_ready = 1'b1;
    tick(); chk("drain1_dir", 32'(direction), 32'h2); chk("drain1_pend", 32'(pending), 32'd3);
    tick(); chk("drain2_dir", 32'(direction), 32'h4); chk("drain2_pend", 32'(pending), 32'd2);
    tick(); chk("drain3_dir", 32'(direction), 32'h8); chk("drain3_pend", 32'(pending), 32'd1);
    tick(); chk("drain4_pend", 32'(pending), 32'd0); chk("drain4_valid", 32'(dir_valid), 32'd0);
    chk("drain_ovf", 32'(overflow), 32'd1);
    core_ready = 1'b0;

    // Flush: three entries, with left still held through the flush.
    press(4'b0001); press(4'b0010);
    btn_raw = 4'b0100;
    repeat (10) tick();
    chk("pre_flush_pend", 32'(pending),  32'd3);
    chk("pre_flush_ovf",  32'(overflow), 32'd1);
    game_state = 2'b10;
    tick();
    chk("flush_pend",  32'(pending),   32'd0);
    chk("flush_valid", 32'(dir_valid), 32'd0);
    chk("flush_ovf",   32'(overflow),  32'd0);
    game_state = 2'b01;
    repeat (12) tick();
    chk("resume_pend", 32'(pending), 32'd0);
    btn_raw = 4'b0000;
    repeat (10) tick();
    chk("resume_pend2", 32'(pending), 32'd0);

    // Full with a pop on the push edge: the push is taken, count stays 4.
    press(4'b0001); press(4'b0010); press(4'b0100); press(4'b1000);
    chk("full2_pend", 32'(pending), 32'd4);
    btn_raw = 4'b0001;
    repeat (7) tick();
    chk("full2_before", 32'(pending), 32'd4);
    core_ready = 1'b1; tick(); core_ready = 1'b0;
    chk("fullpop_pend", 32'(pending),   32'd4);
    chk("fullpop_ovf",  32'(overflow),  32'd0);
    chk("fullpop_dir",  32'(direction), 32'h2);
    btn_raw = 4'b0000;
    repeat (8) tick();
    core_ready = 1'b1;
    tick(); chk("wrap1_dir", 32'(direction), 32'h4); chk("wrap1_pend", 32'(pending), 32'd3);
    tick(); chk("wrap2_dir", 32'(direction), 32'h8); chk("wrap2_pend", 32'(pending), 32'd2);
    tick(); chk("wrap3_dir", 32'(direction), 32'h1); chk("wrap3_pend", 32'(pending), 32'd1);
    tick(); chk("wrap4_pend", 32'(pending), 32'd0);

    // Hold right for 70 cycles with the core always ready.
`ifdef MOVE_AUTO_REPEAT_EN
    exp_moves = 4;
`else
    exp_moves = 1;
`endif
    moves = 0;
    btn_raw = 4'b1000;
    for (int i = 0; i < 110; i++) begin
      if (i == 70) btn_raw = 4'b0000;
      if (dir_valid && core_ready) begin
        chk("repeat_dir", 32'(direction), 32'h8);
        moves++;
      end
      tick();
    end
    chk("repeat_moves", 32'(moves),   32'(exp_moves));
    chk("repeat_pend",  32'(pending), 32'd0);
    core_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
